// File: rtl/axis_decimator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axis_decimator
//
// Purpose:
//   Keeps one of every N accepted AXI-Stream beats and drops the others.
//   It is meant to sit right after axis_moving_average: the average acts as the
//   anti-alias low-pass filter, and this block lowers the sample rate.
//
//   The first beat of each decimation window (phase 0) is kept. It is pushed
//   into a 2-entry output FIFO. The FIFO head drives m_axis_tdata. The slave
//   side ready depends only on the registered FIFO count, so there is no
//   combinational path from m_axis_tready to s_axis_tready.
//
// Parameters:
//   BUS_WIDTH   data width in bytes; tdata is 8*BUS_WIDTH bits
//   RATE_WIDTH  width of the rate port and of the phase counter
//
// Ports:
//   aclk           in   clock, rising edge
//   arstn          in   synchronous active-low reset
//   rate           in   decimation factor N (0 behaves as 1); it is sampled
//                       on each kept beat
//   m_axis_tdata   out  decimated sample (FIFO head)
//   m_axis_tvalid  out  output FIFO not empty (registered)
//   m_axis_tready  in   downstream ready
//   s_axis_tdata   in   input sample
//   s_axis_tvalid  in   input valid
//   s_axis_tready  out  block can accept a beat (FIFO not full, not in reset)
// -----------------------------------------------------------------------------
module axis_decimator #(
  parameter int BUS_WIDTH  = 1,
  parameter int RATE_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic [RATE_WIDTH-1:0]  rate,
  output logic [8*BUS_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic [8*BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready
);

  localparam int DW = 8 * BUS_WIDTH;

  // Decimation state
  logic [RATE_WIDTH-1:0] phase_q, phase_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic [RATE_WIDTH-1:0] rate_sane;
  logic [RATE_WIDTH-1:0] rate_eff;

  // Output FIFO state
  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          tvalid_q, tvalid_d;

  // Handshake and control terms
  logic in_beat;
  logic out_beat;
  logic keep;
  logic push;
  logic pop;

  // Ready comes only from the registered count and the reset pin. Backpressure
  // therefore reaches the upstream one cycle late. The second FIFO entry
  // absorbs the beat that is already in flight.
  assign s_axis_tready = arstn & (count_q != 2'd2);

  assign in_beat  = s_axis_tvalid & s_axis_tready;
  assign out_beat = tvalid_q & m_axis_tready;

  assign keep = (phase_q == '0);
  assign push = in_beat & keep;
  assign pop  = out_beat;

  assign rate_sane = (rate == '0) ? RATE_WIDTH'(1) : rate;

  // At phase 0 the window length is being latched on this very beat. The wrap
  // test must therefore use the freshly sampled value. Otherwise a switch
  // from a long rate to rate 1 would leave the phase counting toward the old
  // limit.
  assign rate_eff = keep ? rate_sane : rate_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d  = phase_q;
    rate_d   = rate_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (in_beat) begin
      if (phase_q == rate_eff - RATE_WIDTH'(1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + RATE_WIDTH'(1);
      end
    end

    if (push) begin
      rate_d   = rate_sane;
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Simultaneous push and pop leaves the occupancy unchanged. With one entry
    // held, the new beat is written behind the head being popped, so it
    // becomes the head on the next cycle.
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    tvalid_d = (count_d != 2'd0);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      phase_q  <= '0;
      rate_q   <= RATE_WIDTH'(1);
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      tvalid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      rate_q   <= rate_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tvalid_q <= tvalid_d;
    end
  end

  // FIFO storage. The entries are cleared on reset so that m_axis_tdata
  // reads as zero until the first kept beat arrives.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  // The head is selected by the registered read pointer, so tdata cannot
  // change while the beat is stalled.
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_decimator.sv
`timescale 1ns/1ps
module tb_axis_decimator;

  localparam int BW = 1;
  localparam int RW = 16;

  logic          aclk = 1'b0;
  logic          arstn;
  logic [RW-1:0] rate;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tready;

  always #5 aclk = ~aclk;

  axis_decimator #(.BUS_WIDTH(BW), .RATE_WIDTH(RW)) dut (
    .aclk         (aclk),
    .arstn        (arstn),
    .rate         (rate),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard: kept beats are pushed when accepted; popped on output beats
  logic [7:0] sb_q[$];
  logic [7:0] out_log[$];
  int         model_phase = 0;
  int         model_rate  = 1;
  int         stall_cnt   = 0;

  typedef struct {
    logic [15:0] rate;
    int          nbeats;
    logic [7:0]  base;
    bit          gap;
    bit          bp;
    int          exp_outs;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    bit          no_stall;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour for one accepted input beat
  function automatic void model_accept(input logic [7:0] d, input int r);
    if (model_phase == 0) begin
      model_rate = (r == 0) ? 1 : r;
      sb_q.push_back(d);
    end
    if (model_phase == model_rate - 1) model_phase = 0;
    else model_phase++;
  endfunction

  // Output monitor: sampled at negedge, so the handshake seen here is the one
  // that completes at the next rising edge
  always @(negedge aclk) begin
    if (arstn && m_tvalid && m_tready) begin
      check("sb_underflow", 32'(sb_q.size() == 0), 32'd0);
      if (sb_q.size() != 0) begin
        logic [7:0] e;
        e = sb_q.pop_front();
        check("out_data", m_tdata, e);
        $display("out beat data=%02h expected=%02h", m_tdata, e);
      end
      out_log.push_back(m_tdata);
    end
  end

  // Drive one beat and wait until it is accepted (bounded)
  task automatic send(input logic [7:0] d, input bit bp);
    bit ok = 0;
    int n  = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    while (!ok && n < 200) begin
      @(negedge aclk);
      if (s_tready) begin
        model_accept(d, int'(rate));
        ok = 1;
      end else begin
        stall_cnt++;
      end
      @(posedge aclk); #1;
      if (bp) m_tready = 1'($urandom_range(0, 1));
      n++;
    end
    s_tvalid = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    m_tready = 1'b1;
    while ((sb_q.size() != 0 || m_tvalid) && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    check("drain_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rate  n   base  gap bp outs first last  no_stall
    vecs[0] = '{16'd1, 8,  8'h10, 0, 0, 8, 8'h10, 8'h17, 1};
    vecs[1] = '{16'd3, 9,  8'h01, 1, 0, 3, 8'h01, 8'h07, 0};
    vecs[2] = '{16'd0, 5,  8'h40, 0, 0, 5, 8'h40, 8'h44, 1};
    vecs[3] = '{16'd2, 6,  8'h00, 0, 1, 3, 8'h00, 8'h04, 0};
    vecs[4] = '{16'd5, 10, 8'h80, 1, 1, 2, 8'h80, 8'h85, 0};
    vecs[5] = '{16'd4, 16, 8'hC0, 0, 1, 4, 8'hC0, 8'hCC, 0};

    arstn    = 1'b0;
    rate     = 16'd1;
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tdata", m_tdata, 8'h00);
    check("rst_s_tready", s_tready, 1'b0);
    arstn = 1'b1;
    tick();
    check("post_rst_s_tready", s_tready, 1'b1);

    // Decimate by 4 with exact one-cycle latency on the kept beats
    rate     = 16'd4;
    m_tready = 1'b1;
    out_log.delete();
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0);
      check("t1_valid", m_tvalid, 32'(i % 4 == 0));
      if (i % 4 == 0) check("t1_data", m_tdata, 32'(i));
    end
    drain();
    check("t1_count", out_log.size(), 4);

    // Table-driven vectors
    for (int v = 0; v < 6; v++) begin
      rate      = vecs[v].rate;
      m_tready  = 1'b1;
      stall_cnt = 0;
      out_log.delete();
      for (int i = 0; i < vecs[v].nbeats; i++) begin
        send(vecs[v].base + 8'(i), vecs[v].bp);
        if (vecs[v].gap) tick();
      end
      drain();
      $display("vector %0d rate=%0d outputs=%0d", v, vecs[v].rate, out_log.size());
      check("vec_outs", out_log.size(), vecs[v].exp_outs);
      if (out_log.size() > 0) begin
        check("vec_first", out_log[0], vecs[v].exp_first);
        check("vec_last", out_log[out_log.size()-1], vecs[v].exp_last);
      end
      if (vecs[v].no_stall) check("vec_no_stall", stall_cnt, 0);
    end

    // Backpressure: buffer fills after two beats and the head stays stable
    rate     = 16'd1;
    m_tready = 1'b0;
    out_log.delete();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 8'hA3;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("t3_s_tready", s_tready, 1'b0);
      check("t3_m_tvalid", m_tvalid, 1'b1);
      check("t3_hold_data", m_tdata, 8'hA1);
      tick();
    end
    m_tready = 1'b1;
    send(8'hA3, 1'b0);
    drain();
    check("t3_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("t3_o0", out_log[0], 8'hA1);
      check("t3_o1", out_log[1], 8'hA2);
      check("t3_o2", out_log[2], 8'hA3);
    end

    // Rate change mid-window takes effect at the next window
    rate = 16'd2;
    out_log.delete();
    for (int i = 0; i < 3; i++) send(8'(i), 1'b0);
    rate = 16'd5;
    for (int i = 3; i < 14; i++) send(8'(i), 1'b0);
    drain();
    check("t5_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      check("t5_o0", out_log[0], 8'd0);
      check("t5_o1", out_log[1], 8'd2);
      check("t5_o2", out_log[2], 8'd4);
      check("t5_o3", out_log[3], 8'd9);
    end

    // Reset mid-stream with a full buffer and phase 1
    rate     = 16'd3;
    m_tready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    send(8'h14, 1'b0);
    check("t6_full", s_tready, 1'b0);
    check("t6_pre_valid", m_tvalid, 1'b1);
    arstn = 1'b0;
    @(negedge aclk);
    check("t6_rst_s_tready", s_tready, 1'b0);
    tick();
    check("t6_rst_m_tvalid", m_tvalid, 1'b0);
    check("t6_rst_m_tdata", m_tdata, 8'h00);
    check("t6_rst_s_tready2", s_tready, 1'b0);
    arstn = 1'b1;
    sb_q.delete();
    model_phase = 0;
    model_rate  = 1;
    out_log.delete();
    m_tready = 1'b1;
    send(8'h55, 1'b0);
    check("t6_first_kept", m_tvalid, 1'b1);
    check("t6_first_data", m_tdata, 8'h55);
    send(8'h56, 1'b0);
    send(8'h57, 1'b0);
    drain();
    check("t6_count", out_log.size(), 1);
    if (out_log.size() == 1) check("t6_o0", out_log[0], 8'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
